// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_ctrl
// Purpose  : Scan sequencer for a 4-to-1 mux. It drives the mux select, holds
//            each channel for DWELL cycles and samples the mux output at the
//            end of each dwell. After all four channels are sampled, it
//            publishes one packed frame with a single-cycle valid pulse.
//            Both single-shot and continuous scanning are supported.
// Optional : MUX_SCAN_CHANGE_DET_EN -- when defined, chg_mask flags each
//            channel whose new value differs from the previous frame. When it
//            is undefined, chg_mask is tied to zero.
// Ports    : clk          system clock, rising edge
//            rst_n        asynchronous active-low reset
//            start        begin a scan (sampled only in IDLE)
//            stop         abort/end scanning (highest priority)
//            cont         continuous mode (sampled in DONE)
//            mux_out      [DATA_W-1:0] output of the 4-to-1 mux
//            sel          [1:0] channel select to the mux
//            busy         high whenever the state is not IDLE
//            frame_valid  one-cycle pulse when a new frame is published
//            frame_data   [4*DATA_W-1:0] last complete frame, ch0 in the LSBs
//            chg_mask     [3:0] per-channel change flags
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int DATA_W = 4,
  parameter int DWELL  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                cont,
  input  logic [DATA_W-1:0]   mux_out,
  output logic [1:0]          sel,
  output logic                busy,
  output logic                frame_valid,
  output logic [4*DATA_W-1:0] frame_data,
  output logic [3:0]          chg_mask
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] slot [4];

  // The frame being completed: ch3 comes straight from the mux on the edge
  // that captures it, so the published frame already includes it.
  logic [4*DATA_W-1:0] new_frame;
  assign new_frame = {mux_out, slot[2], slot[1], slot[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= 2'd0;
      cnt         <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      for (int k = 0; k < 4; k++) begin
        slot[k] <= '0;
      end
    end else if (stop) begin
      // Any partial frame is dropped. frame_data keeps the last good frame.
      state       <= IDLE;
      sel         <= 2'd0;
      cnt         <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel         <= 2'd0;
          frame_valid <= 1'b0;
          if (start) begin
            state <= SCAN;
            cnt   <= RELOAD;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            slot[sel] <= mux_out;
            if (sel != 2'd3) begin
              sel <= sel + 2'd1;
              cnt <= RELOAD;
            end else begin
              state       <= DONE;
              frame_data  <= new_frame;
              frame_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          frame_valid <= 1'b0;
          sel         <= 2'd0;
          if (cont) begin
            state <= SCAN;
            cnt   <= RELOAD;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          sel         <= 2'd0;
          busy        <= 1'b0;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_SCAN_CHANGE_DET_EN
  // The mask is compared against the frame being replaced. The first frame
  // after reset is compared against the cleared frame_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_mask <= 4'b0000;
    end else if (!stop && state == SCAN && cnt == '0 && sel == 2'd3) begin
      for (int k = 0; k < 4; k++) begin
        chg_mask[k] <= (new_frame[k*DATA_W +: DATA_W] !=
                        frame_data[k*DATA_W +: DATA_W]);
      end
    end
  end
`else
  assign chg_mask = 4'b0000;
`endif

endmodule
`default_nettype wire
